// File: rtl/comm_serial_tx_if.sv
// Handshake and serial-line bundle for comm_serial_tx.
// The master side requests frames; the slave side is the transmitter.
interface comm_serial_tx_if #(
  parameter int DATA_W = 7
);
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              tx_done;
  logic              data_out;
  logic              lock;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, tx_done, data_out, lock
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, tx_done, data_out, lock
  );
endinterface

// File: rtl/comm_serial_tx.sv
// Parallel-to-serial transmitter: MSB first on data_out, with an active-low
// lock strobe asserted once per bit for a receiver shifting while !lock.
//
// state   | meaning
// S_IDLE  | waiting for tx_start; lock high, data_out low
// S_SHIFT | holding shreg MSB on data_out for BIT_CYCLES cycles per bit
// S_GAP   | lock high for GAP_CYCLES cycles before returning with tx_done
module comm_serial_tx #(
  parameter int DATA_W     = 7,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  comm_serial_tx_if.slave   s_tx
);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic [BW-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [CW-1:0]     r_cyc_cnt, w_cyc_cnt_nxt;
  logic [GW-1:0]     r_gap_cnt, w_gap_cnt_nxt;
  logic              w_done_nxt;
  logic              r_data_out, r_lock, r_busy, r_done;

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_cyc_cnt_nxt = r_cyc_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (s_tx.tx_start) begin
          w_shreg_nxt   = s_tx.tx_data;
          w_bit_cnt_nxt = '0;
          w_cyc_cnt_nxt = '0;
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cyc_cnt == CYC_LAST) begin
          w_shreg_nxt   = {r_shreg[DATA_W-2:0], 1'b0};
          w_cyc_cnt_nxt = '0;
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_cnt_nxt = '0;
            w_gap_cnt_nxt = GAP_LAST;
            w_state_nxt   = S_GAP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end else begin
          w_cyc_cnt_nxt = r_cyc_cnt + CW'(1);
        end
      end
      S_GAP: begin
        // gap timer runs down and terminates at zero
        if (r_gap_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so lock and data_out
  // change on the same edge and stay stable through the lock-low cycle.
  always_ff @(posedge i_sys_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_cyc_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_data_out <= 1'b0;
      r_lock     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_cyc_cnt  <= w_cyc_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_data_out <= (w_state_nxt == S_SHIFT) & w_shreg_nxt[DATA_W-1];
      r_lock     <= !((w_state_nxt == S_SHIFT) && (w_cyc_cnt_nxt == CYC_LAST));
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
    end
  end

  assign s_tx.data_out = r_data_out;
  assign s_tx.lock     = r_lock;
  assign s_tx.tx_busy  = r_busy;
  assign s_tx.tx_done  = r_done;
endmodule
